// File: rtl/poly_phase_accu.sv
// Time-multiplexed multi-voice phase accumulator: one voice per cycle per sample tick.
// Optional FCW glide (slewed frequency changes) is enabled by defining PPA_GLIDE_EN.
module poly_phase_accu #(
  parameter int VOICES      = 8,
  parameter int ACC_W       = 24,
  parameter int ADDR_W      = 16,
  parameter int GLIDE_SHIFT = 6
) (
  input  logic                       i_clk50mhz,
  input  logic                       i_rst,
  input  logic                       i_tick,
  input  logic                       i_wr_en,
  input  logic [$clog2(VOICES)-1:0]  i_wr_voice,
  input  logic [ACC_W-1:0]           i_wr_fcw,
  input  logic                       i_wr_sync,
  output logic                       o_valid,
  output logic [$clog2(VOICES)-1:0]  o_voice,
  output logic [ADDR_W-1:0]          o_addr,
  output logic                       o_busy,
  output logic                       o_overrun
);

  localparam int VW = $clog2(VOICES);
  // The scan counter has to reach VOICES so the last RUN cycle can absorb a late tick.
  localparam int CW = VW + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     cnt_s;
  logic              upd_s;
  logic [VW-1:0]     upd_voice_s;
  logic              tick_drop_s;
  logic              wr_ok_s;
  logic [ACC_W-1:0]  fcw_use_s;
  logic [ACC_W-1:0]  phase_new_s;

  logic [ACC_W-1:0]  phase_r   [VOICES];
  logic [ACC_W-1:0]  fcw_tgt_r [VOICES];
  logic [VOICES-1:0] sync_r;

  if (VOICES < 2 || VOICES > 64 || ADDR_W > ACC_W || GLIDE_SHIFT < 0) begin : g_bad_params
    $error("poly_phase_accu: illegal parameter combination");
  end

  if ((1 << VW) == VOICES) begin : g_wr_full
    assign wr_ok_s = i_wr_en;
  end else begin : g_wr_part
    assign wr_ok_s = i_wr_en && (i_wr_voice < VW'(VOICES));
  end

  // Scan sequencing: the tick cycle itself updates voice 0, RUN covers voices 1..VOICES-1 plus one tail cycle.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    upd_s       = 1'b0;
    upd_voice_s = '0;
    tick_drop_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_tick) begin
          state_s = ST_RUN;
          cnt_s   = CW'(1);
          upd_s   = 1'b1;
        end else begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end
      end
      ST_RUN: begin
        tick_drop_s = i_tick;
        if (cnt_r == CW'(VOICES)) begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end else begin
          upd_s       = 1'b1;
          upd_voice_s = cnt_r[VW-1:0];
          cnt_s       = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

`ifdef PPA_GLIDE_EN
  logic [ACC_W-1:0]      fcw_cur_r [VOICES];
  logic signed [ACC_W:0] diff_s;
  logic signed [ACC_W:0] step_s;
  logic [ACC_W-1:0]      glide_new_s;

  assign fcw_use_s = fcw_cur_r[upd_voice_s];

  // Glide step: move fcw_cur toward the target by diff/2^GLIDE_SHIFT, snapping once the step rounds to zero.
  always_comb begin
    diff_s = $signed({1'b0, fcw_tgt_r[upd_voice_s]}) - $signed({1'b0, fcw_cur_r[upd_voice_s]});
    step_s = diff_s >>> GLIDE_SHIFT;
    if (step_s != '0) begin
      glide_new_s = fcw_cur_r[upd_voice_s] + step_s[ACC_W-1:0];
    end else begin
      glide_new_s = fcw_tgt_r[upd_voice_s];
    end
  end

  // Per-voice current FCW, advanced only when that voice is updated.
  always_ff @(posedge i_clk50mhz or posedge i_rst) begin
    if (i_rst) begin
      for (int v = 0; v < VOICES; v++) begin
        fcw_cur_r[v] <= '0;
      end
    end else if (upd_s) begin
      fcw_cur_r[upd_voice_s] <= glide_new_s;
    end
  end
`else
  assign fcw_use_s = fcw_tgt_r[upd_voice_s];
`endif

  // New phase for the voice being stepped; a pending sync replaces the add with zero.
  always_comb begin
    if (sync_r[upd_voice_s]) begin
      phase_new_s = '0;
    end else begin
      phase_new_s = phase_r[upd_voice_s] + fcw_use_s;
    end
  end

  // Phase, target FCW and sync-pending storage; a write on the update edge lands after the update.
  always_ff @(posedge i_clk50mhz or posedge i_rst) begin
    if (i_rst) begin
      for (int v = 0; v < VOICES; v++) begin
        phase_r[v]   <= '0;
        fcw_tgt_r[v] <= '0;
      end
      sync_r <= '0;
    end else begin
      if (upd_s) begin
        phase_r[upd_voice_s] <= phase_new_s;
        sync_r[upd_voice_s]  <= 1'b0;
      end
      if (wr_ok_s) begin
        fcw_tgt_r[i_wr_voice] <= i_wr_fcw;
        if (i_wr_sync) begin
          sync_r[i_wr_voice] <= 1'b1;
        end
      end
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge i_clk50mhz or posedge i_rst) begin
    if (i_rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      o_valid   <= 1'b0;
      o_voice   <= '0;
      o_addr    <= '0;
      o_busy    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      o_valid   <= upd_s;
      o_voice   <= upd_s ? upd_voice_s : '0;
      o_addr    <= upd_s ? phase_new_s[ACC_W-1 -: ADDR_W] : '0;
      o_busy    <= (state_s == ST_RUN);
      o_overrun <= tick_drop_s;
    end
  end

endmodule

// File: tb/tb_poly_phase_accu.sv
// Directed self-checking bench for poly_phase_accu (default build, 8 voices, 24/16-bit).
module tb_poly_phase_accu;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        wr_en;
  logic [2:0]  wr_voice;
  logic [23:0] wr_fcw;
  logic        wr_sync;
  logic        valid;
  logic [2:0]  voice;
  logic [15:0] addr;
  logic        busy;
  logic        overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [15:0] exp_addr [8];

  poly_phase_accu #(.VOICES(8), .ACC_W(24), .ADDR_W(16), .GLIDE_SHIFT(6)) dut (
    .i_clk50mhz (clk),
    .i_rst      (rst),
    .i_tick     (tick),
    .i_wr_en    (wr_en),
    .i_wr_voice (wr_voice),
    .i_wr_fcw   (wr_fcw),
    .i_wr_sync  (wr_sync),
    .o_valid    (valid),
    .o_voice    (voice),
    .o_addr     (addr),
    .o_busy     (busy),
    .o_overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_exp(input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] a2, input logic [15:0] a3);
    exp_addr[0] = a0; exp_addr[1] = a1; exp_addr[2] = a2; exp_addr[3] = a3;
    for (int i = 4; i < 8; i++) exp_addr[i] = 16'h0000;
  endtask

  task automatic write(input logic [2:0] v, input logic [23:0] f, input logic s);
    wr_en = 1'b1; wr_voice = v; wr_fcw = f; wr_sync = s;
    @(negedge clk);
    wr_en = 1'b0; wr_sync = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One scan: tick, check 8 outputs, optional extra tick after iteration drop_at,
  // optional write issued during iteration wr_at.
  task automatic do_scan(input string tag, input int drop_at, input int wr_at,
                         input logic [2:0] wv, input logic [23:0] wf, input logic ws);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    for (int v = 0; v < 8; v++) begin
      chk({tag, "_valid"}, 32'(valid), 32'd1);
      chk({tag, "_voice"}, 32'(voice), 32'(v));
      chk({tag, "_addr"}, 32'(addr), 32'(exp_addr[v]));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_ovr"}, 32'(overrun), (drop_at >= 0 && v == drop_at + 1) ? 32'd1 : 32'd0);
      tick = (v == drop_at) ? 1'b1 : 1'b0;
      if (v == wr_at) begin
        wr_en = 1'b1; wr_voice = wv; wr_fcw = wf; wr_sync = ws;
      end else begin
        wr_en = 1'b0; wr_sync = 1'b0;
      end
      @(negedge clk);
    end
    tick = 1'b0; wr_en = 1'b0; wr_sync = 1'b0;
    chk({tag, "_end_valid"}, 32'(valid), 32'd0);
    chk({tag, "_end_busy"}, 32'(busy), 32'd0);
    chk({tag, "_end_ovr"}, 32'(overrun), (drop_at == 7) ? 32'd1 : 32'd0);
    @(negedge clk);
    chk({tag, "_post_valid"}, 32'(valid), 32'd0);
    chk({tag, "_post_ovr"}, 32'(overrun), 32'd0);
    idle(8);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; wr_en = 1'b0; wr_voice = 3'd0; wr_fcw = 24'd0; wr_sync = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    write(3'd0, 24'h000100, 1'b0);
    set_exp(16'h0001, 16'h0000, 16'h0000, 16'h0000); do_scan("scanA", -1, -1, 3'd0, 24'd0, 1'b0);
    set_exp(16'h0002, 16'h0000, 16'h0000, 16'h0000); do_scan("scanB", -1, -1, 3'd0, 24'd0, 1'b0);
    set_exp(16'h0003, 16'h0000, 16'h0000, 16'h0000); do_scan("scanC", -1, -1, 3'd0, 24'd0, 1'b0);

    // Wrap: voice 3 phase FFFFFF then FFFFFE (silent modulo wrap).
    write(3'd3, 24'hFFFFFF, 1'b0);
    set_exp(16'h0004, 16'h0000, 16'h0000, 16'hFFFF); do_scan("wrapD", -1, -1, 3'd0, 24'd0, 1'b0);
    set_exp(16'h0005, 16'h0000, 16'h0000, 16'hFFFF); do_scan("wrapE", -1, -1, 3'd0, 24'd0, 1'b0);

    // Tick while busy mid-scan is dropped with a one-cycle overrun.
    set_exp(16'h0006, 16'h0000, 16'h0000, 16'hFFFF); do_scan("ovrF", 3, -1, 3'd0, 24'd0, 1'b0);

    write(3'd2, 24'h000200, 1'b0);
    set_exp(16'h0007, 16'h0000, 16'h0002, 16'hFFFF); do_scan("scanG", -1, -1, 3'd0, 24'd0, 1'b0);
    // Sync on voice 2 issued before voice 2 is reached.
    set_exp(16'h0008, 16'h0000, 16'h0000, 16'hFFFF); do_scan("syncH", -1, 0, 3'd2, 24'h000200, 1'b1);
    set_exp(16'h0009, 16'h0000, 16'h0002, 16'hFFFF); do_scan("scanI", -1, -1, 3'd0, 24'd0, 1'b0);
    // Write to voice 1 on its own update cycle; tick on the last RUN cycle is dropped.
    set_exp(16'h000A, 16'h0000, 16'h0004, 16'hFFFF); do_scan("sameJ", 7, 0, 3'd1, 24'h001000, 1'b0);
    set_exp(16'h000B, 16'h0010, 16'h0006, 16'hFFFF); do_scan("scanK", -1, -1, 3'd0, 24'd0, 1'b0);

    // Reset in cycle t+4 of a scan clears everything asynchronously.
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    idle(3);
    chk("pre_rst_valid", 32'(valid), 32'd1);
    chk("pre_rst_voice", 32'(voice), 32'd3);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_voice", 32'(voice), 32'd0);
    chk("arst_addr", 32'(addr), 32'd0);
    chk("arst_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(valid), 32'd0);
    end
    set_exp(16'h0000, 16'h0000, 16'h0000, 16'h0000); do_scan("rstL", -1, -1, 3'd0, 24'd0, 1'b0);
    write(3'd0, 24'h000100, 1'b0);
    set_exp(16'h0001, 16'h0000, 16'h0000, 16'h0000); do_scan("rstM", -1, -1, 3'd0, 24'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
